// File: rtl/cla_pkg.sv
// Shared lookahead helpers and configuration checks for the pipelined CLA adder/subtractor.
// Functions take MAXN-wide vectors so one definition serves every GROUP/slice size.
package cla_pkg;

   localparam int MAXN = 32;

   typedef struct packed {
      logic p;
      logic g;
   } pg_t;

   function automatic int slice_w(input int w, input int s);
      return w / s;
   endfunction

   function automatic int ngroups(input int w, input int g, input int s);
      return w / (g * s);
   endfunction

   function automatic bit cfg_ok(input int w, input int g, input int s);
      return (w > 0) && (g > 0) && (s > 0) && ((w % (g * s)) == 0) &&
             (g <= MAXN) && ((w / (g * s)) <= MAXN);
   endfunction

   // Carry into position j as a flat sum of products of g/p terms and cin,
   // so no carry depends on another carry.
   function automatic logic carry_at(input logic [MAXN-1:0] p, input logic [MAXN-1:0] g,
                                     input logic cin, input int j);
      logic run;
      logic c;
      run = 1'b1;
      c   = 1'b0;
      for (int i = MAXN - 1; i >= 0; i--) begin
         if (i < j) begin
            c   = c | (run & g[i]);
            run = run & p[i];
         end
      end
      return c | (run & cin);
   endfunction

   function automatic pg_t group_pg(input logic [MAXN-1:0] p, input logic [MAXN-1:0] g,
                                    input int n);
      pg_t r;
      r.g = carry_at(p, g, 1'b0, n);
      r.p = 1'b1;
      for (int i = 0; i < MAXN; i++) begin
         if (i < n) r.p = r.p & p[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/cla_slice.sv
// One SLICE-wide two-level carry-lookahead adder: group Pm/Gm, then inter-group
// carries from cin, then in-group bit carries from each group's carry-in.
module cla_slice
   import cla_pkg::*;
#(
   parameter int SLICE = 16,
   parameter int GROUP = 4
)(
   input  logic [SLICE-1:0] a_i,
   input  logic [SLICE-1:0] b_i,
   input  logic             cin_i,
   output logic [SLICE-1:0] sum_o,
   output logic             cout_o,
   output logic             c_msb_o
);

   localparam int NG = SLICE / GROUP;

   logic [SLICE-1:0] p, g, c;
   logic [NG-1:0]    gp, gg;
   logic [NG:0]      gc;

   assign p = a_i ^ b_i;
   assign g = a_i & b_i;

   for (genvar j = 0; j < NG; j++) begin : g_grp
      pg_t pg;
      assign pg    = group_pg(MAXN'(p[j*GROUP +: GROUP]), MAXN'(g[j*GROUP +: GROUP]), GROUP);
      assign gp[j] = pg.p;
      assign gg[j] = pg.g;
   end

   for (genvar j = 0; j <= NG; j++) begin : g_gc
      assign gc[j] = carry_at(MAXN'(gp), MAXN'(gg), cin_i, j);
   end

   for (genvar j = 0; j < NG; j++) begin : g_bits
      for (genvar i = 0; i < GROUP; i++) begin : g_bit
         assign c[j*GROUP + i] = carry_at(MAXN'(p[j*GROUP +: GROUP]),
                                          MAXN'(g[j*GROUP +: GROUP]), gc[j], i);
      end
   end

   assign sum_o   = p ^ c;
   assign cout_o  = gc[NG];
   assign c_msb_o = c[SLICE-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined CLA adder/subtractor: stage k resolves operand slice k and forwards its carry;
// valid/ready handshake with full backpressure and bubble collapse.
module cla_pipe_addsub
   import cla_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int GROUP  = 4,
   parameter int STAGES = 2
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int SLICE = slice_w(WIDTH, STAGES);

   if (!cfg_ok(WIDTH, GROUP, STAGES)) begin : g_bad_cfg
      $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP*STAGES");
   end

   logic [STAGES-1:0] vld_q, vld_d, ld;
   logic [WIDTH-1:0]  b_cond;
   logic              c0;
   logic              all_full;

   // Subtraction as a + ~b + ~cin: cin becomes a borrow, cout=1 means no borrow.
   assign b_cond = in_b ^ {WIDTH{in_sub}};
   assign c0     = in_cin ^ in_sub;

   // Stage k loads iff some stage at or after k is empty, or the output drains;
   // flattened so there is no combinational chain between stages.
   always_comb begin
      all_full = 1'b1;
      ld       = '0;
      for (int k = 0; k < STAGES; k++) begin
         all_full = 1'b1;
         for (int j = 0; j < STAGES; j++) begin
            if (j >= k) all_full = all_full & vld_q[j];
         end
         ld[k] = out_ready | ~all_full;
      end
   end

   assign in_ready = ld[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int UW = WIDTH - k * SLICE;
      localparam int SW = (k + 1) * SLICE;

      logic [UW-1:0]    ua, ub;
      logic             uc, uv;
      logic [SLICE-1:0] s;
      logic             co, cm;
      logic [SW-1:0]    sum_d, sum_q;
      logic             cy_q;

      if (k == 0) begin : g_src
         assign ua    = in_a;
         assign ub    = b_cond;
         assign uc    = c0;
         assign uv    = in_valid;
         assign sum_d = s;
      end else begin : g_src
         assign ua    = g_stg[k-1].g_ops.a_q;
         assign ub    = g_stg[k-1].g_ops.b_q;
         assign uc    = g_stg[k-1].cy_q;
         assign uv    = vld_q[k-1];
         assign sum_d = {s, g_stg[k-1].sum_q};
      end

      cla_slice #(.SLICE(SLICE), .GROUP(GROUP)) u_slice (
         .a_i     (ua[SLICE-1:0]),
         .b_i     (ub[SLICE-1:0]),
         .cin_i   (uc),
         .sum_o   (s),
         .cout_o  (co),
         .c_msb_o (cm)
      );

      assign vld_d[k] = ld[k] ? uv : vld_q[k];

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            sum_q <= '0;
            cy_q  <= 1'b0;
         end else if (ld[k] && uv) begin
            sum_q <= sum_d;
            cy_q  <= co;
         end
      end

      if (k < STAGES - 1) begin : g_ops
         logic [UW-SLICE-1:0] a_q, b_q;
         logic                unused_cm;
         assign unused_cm = cm;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (ld[k] && uv) begin
               a_q <= ua[UW-1:SLICE];
               b_q <= ub[UW-1:SLICE];
            end
         end
      end else begin : g_fl
         logic cm_q;
         always_ff @(posedge clk) begin
            if (!rst_n)               cm_q <= 1'b0;
            else if (ld[k] && uv)     cm_q <= cm;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld_d;
   end

   assign out_valid = vld_q[STAGES-1];
   assign out_sum   = g_stg[STAGES-1].sum_q;
   assign out_cout  = g_stg[STAGES-1].cy_q;
   assign out_ovf   = g_stg[STAGES-1].g_fl.cm_q ^ g_stg[STAGES-1].cy_q;
   // Gated by valid so the flag reads 0 out of reset rather than "sum is zero".
   assign out_zero  = vld_q[STAGES-1] & ~|out_sum;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench: default 32/4/2 instance for directed steps, 16/4/1 instance for random traffic.
module tb_cla_pipe_addsub;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        a_in_valid, a_in_ready, a_in_sub, a_in_cin;
   logic [31:0] a_in_a, a_in_b, a_out_sum;
   logic        a_out_valid, a_out_ready, a_out_cout, a_out_ovf, a_out_zero;
   logic        b_in_valid, b_in_ready, b_in_sub, b_in_cin;
   logic [15:0] b_in_a, b_in_b, b_out_sum;
   logic        b_out_valid, b_out_ready, b_out_cout, b_out_ovf, b_out_zero;

   cla_pipe_addsub u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_a(a_in_a), .in_b(a_in_b),
      .in_sub(a_in_sub), .in_cin(a_in_cin),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum),
      .out_cout(a_out_cout), .out_ovf(a_out_ovf), .out_zero(a_out_zero)
   );

   cla_pipe_addsub #(.WIDTH(16), .GROUP(4), .STAGES(1)) u_dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_a(b_in_a), .in_b(b_in_b),
      .in_sub(b_in_sub), .in_cin(b_in_cin),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
      .out_cout(b_out_cout), .out_ovf(b_out_ovf), .out_zero(b_out_zero)
   );

   res_t qa[$];
   res_t qb[$];
   int   errors = 0;
   int   checks = 0;
   bit   lat_b  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on w-bit operands.
   function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, input logic cin);
      longint m  = longint'(1) << w;
      longint ua = longint'(a);
      longint ub = longint'(b);
      longint ci = longint'(cin);
      longint sa, sb, r, rs;
      res_t   x;
      sa     = (ua >= m / 2) ? ua - m : ua;
      sb     = (ub >= m / 2) ? ub - m : ub;
      r      = sub ? ua - ub - ci : ua + ub + ci;
      rs     = sub ? sa - sb - ci : sa + sb + ci;
      x.sum  = 32'(r & (m - 1));
      x.cout = sub ? (r >= 0) : (r >= m);
      x.ovf  = (rs >= m / 2) || (rs < -(m / 2));
      x.zero = ((r & (m - 1)) == 0);
      return x;
   endfunction

   always @(negedge clk) begin
      res_t e;
      if (rst_n) begin
         if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) chk("a_unexpected_out", 32'd1, 32'd0);
            else begin
               e = qa.pop_front();
               chk("a_sum", a_out_sum, e.sum);
               chk("a_cout", 32'(a_out_cout), 32'(e.cout));
               chk("a_ovf", 32'(a_out_ovf), 32'(e.ovf));
               chk("a_zero", 32'(a_out_zero), 32'(e.zero));
            end
         end
         if (a_in_valid && a_in_ready) qa.push_back(model(32, a_in_a, a_in_b, a_in_sub, a_in_cin));
         if (lat_b) chk("b_latency1", 32'(b_out_valid), 32'd1);
         if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) chk("b_unexpected_out", 32'd1, 32'd0);
            else begin
               e = qb.pop_front();
               chk("b_sum", 32'(b_out_sum), e.sum);
               chk("b_cout", 32'(b_out_cout), 32'(e.cout));
               chk("b_ovf", 32'(b_out_ovf), 32'(e.ovf));
               chk("b_zero", 32'(b_out_zero), 32'(e.zero));
            end
         end
         lat_b = b_in_valid && b_in_ready;
         if (b_in_valid && b_in_ready)
            qb.push_back(model(16, 32'(b_in_a), 32'(b_in_b), b_in_sub, b_in_cin));
      end else begin
         lat_b = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge with in_valid still set.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin);
      int n;
      a_in_valid = 1'b1; a_in_a = a; a_in_b = b; a_in_sub = sub; a_in_cin = cin;
      n = 0;
      @(negedge clk);
      while (!a_in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!a_in_ready) chk("send_timeout", 32'd0, 32'd1);
      step();
   endtask

   logic [31:0] bp_a[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
   int acc, idx, n;

   initial begin
      rst_n = 1'b0;
      a_in_valid = 0; a_in_a = 0; a_in_b = 0; a_in_sub = 0; a_in_cin = 0; a_out_ready = 1;
      b_in_valid = 0; b_in_a = 0; b_in_b = 0; b_in_sub = 0; b_in_cin = 0; b_out_ready = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_out_sum", a_out_sum, 32'd0);
      chk("rst_out_cout", 32'(a_out_cout), 32'd0);
      chk("rst_out_ovf", 32'(a_out_ovf), 32'd0);
      chk("rst_out_zero", 32'(a_out_zero), 32'd0);
      chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(a_in_ready), 32'd1);

      // Latency 2 on an empty pipe: FFFFFFFF + 1 wraps to zero with carry out.
      step();
      send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      a_in_valid = 1'b0;
      @(negedge clk);
      chk("lat_edge1", 32'(a_out_valid), 32'd0);
      @(negedge clk);
      chk("lat_edge2", 32'(a_out_valid), 32'd1);

      step();
      send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
      send(32'h8000_0000, 32'h1, 1'b1, 1'b0);
      send(32'd5, 32'd7, 1'b1, 1'b0);
      send(32'd7, 32'd5, 1'b1, 1'b1);
      send(32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b1);
      a_in_valid = 1'b0;
      repeat (4) step();

      // Backpressure: four offers into a stalled pipe.
      a_out_ready = 1'b0;
      acc = 0; idx = 0;
      for (int c = 0; c < 4; c++) begin
         a_in_valid = 1'b1; a_in_a = bp_a[idx]; a_in_b = 32'd3; a_in_sub = 1'b0; a_in_cin = 1'b0;
         @(negedge clk);
         if (a_in_ready) begin acc++; idx++; end
         step();
      end
      @(negedge clk);
      chk("bp_in_ready", 32'(a_in_ready), 32'd0);
      chk("bp_accepted", 32'(acc), 32'd2);
      chk("bp_hold_valid", 32'(a_out_valid), 32'd1);
      chk("bp_hold_sum0", a_out_sum, qa[0].sum);
      step();
      a_in_valid = 1'b0;
      @(negedge clk);
      chk("bp_hold_sum1", a_out_sum, qa[0].sum);
      step();
      a_out_ready = 1'b1;
      @(negedge clk);
      chk("bp_drain0", 32'(a_out_valid), 32'd1);
      step();
      @(negedge clk);
      chk("bp_drain1", 32'(a_out_valid), 32'd1);
      step();
      for (int i = 2; i < 4; i++) send(bp_a[i], 32'd3, 1'b0, 1'b0);
      a_in_valid = 1'b0;
      repeat (4) step();

      // Full pipe, simultaneous output and input accept.
      a_out_ready = 1'b0;
      send(32'd100, 32'd1, 1'b1, 1'b0);
      send(32'd200, 32'd2, 1'b0, 1'b1);
      a_in_a = 32'd300; a_in_b = 32'd300; a_in_sub = 1'b1; a_in_cin = 1'b0;
      a_out_ready = 1'b1;
      @(negedge clk);
      chk("full_shift_in_ready", 32'(a_in_ready), 32'd1);
      step();
      a_in_valid = 1'b0;
      repeat (4) step();

      // Reset with two operations in flight.
      a_out_ready = 1'b0;
      send(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0);
      send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1);
      a_in_valid = 1'b0;
      rst_n = 1'b0;
      qa.delete();
      qb.delete();
      step();
      rst_n = 1'b1;
      a_out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_valid", 32'(a_out_valid), 32'd0);
      chk("midrst_sum", a_out_sum, 32'd0);
      chk("midrst_cout", 32'(a_out_cout), 32'd0);
      chk("midrst_ovf", 32'(a_out_ovf), 32'd0);
      chk("midrst_zero", 32'(a_out_zero), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         @(negedge clk);
         chk("midrst_no_stale", 32'(a_out_valid), 32'd0);
      end

      // Random traffic on both instances.
      for (int i = 0; i < 10000; i++) begin
         step();
         b_in_valid  = 1'($urandom_range(0, 1));
         b_out_ready = 1'($urandom_range(0, 1));
         b_in_a   = 16'($urandom);
         b_in_b   = (i % 17 == 0) ? 16'hFFFF - b_in_a : 16'($urandom);
         b_in_sub = 1'($urandom_range(0, 1));
         b_in_cin = 1'($urandom_range(0, 1));
         a_in_valid  = 1'($urandom_range(0, 1));
         a_out_ready = 1'($urandom_range(0, 3) != 0);
         a_in_a   = $urandom;
         a_in_b   = $urandom;
         a_in_sub = 1'($urandom_range(0, 1));
         a_in_cin = 1'($urandom_range(0, 1));
      end
      step();
      a_in_valid = 1'b0; b_in_valid = 1'b0; a_out_ready = 1'b1; b_out_ready = 1'b1;
      n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
         step();
         n++;
      end
      @(negedge clk);
      chk("drain_qa_empty", 32'(qa.size()), 32'd0);
      chk("drain_qb_empty", 32'(qb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
